pool1_reader: RTL and testbench
===============================

POOL1_READER -- requirements
Module: pool1_reader

Interface
REQ-001 Parameter IN_DIM, default 55, meaning input feature-map height/width.
REQ-002 Parameter OUT_DIM, default 27, meaning pooled output height/width.
REQ-003 Parameter CH, default 96, meaning channel count.
REQ-004 Parameter DW, default 16, meaning signed data width.
REQ-005 Parameter AW, default 19, meaning feature-map address width.
REQ-006 Port clk, input, 1, meaning the single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst_n, input, 1, meaning synchronous active-low reset.
REQ-008 Port start, input, 1, meaning begin one full pooling pass.
REQ-009 Port busy, output, 1, meaning a pass is in progress.
REQ-010 Port done, output, 1, meaning one-cycle pulse at pass end.
REQ-011 Port mem_rd_en, output, 1, meaning feature-map read request.
REQ-012 Port mem_addr, output, AW, meaning read address = (row*IN_DIM+col)*CH+ch.
REQ-013 Port mem_rd_data, input, DW, meaning read data, valid exactly 1 cycle after mem_rd_en.
REQ-014 Port out_valid, output, 1, meaning pooled result available.
REQ-015 Port out_ready, input, 1, meaning downstream accepts result.
REQ-016 Port out_data, output, DW, meaning signed max of the 3x3 window.
REQ-017 Port out_row/out_col, output, 5 each, meaning output pixel coordinates oy/ox.
REQ-018 Port out_ch, output, 7, meaning output channel k.

Function
REQ-019 Block SHALL read the ReLU'd conv1 map (IN_DIM x IN_DIM x CH) and produce 3x3 stride-2 max-pool (OUT_DIM x OUT_DIM x CH).
REQ-020 FSM states SHALL be IDLE, READ, DRAIN, EMIT, FIN.
REQ-021 IDLE: start=1 SHALL load oy=ox=k=0, tap=0, go to READ; start ignored in all other states.
REQ-022 READ: one read per cycle, taps 0..8 in order dy=tap/3, dx=tap%3, row=2*oy+dy, col=2*ox+dx; after tap 8 go to DRAIN.
REQ-023 DRAIN: one cycle, no read, captures tap-8 data; then EMIT.
REQ-024 Accumulator SHALL load tap-0 data directly (no zero init) and thereafter take signed max; comparisons SHALL be DW-bit two's-complement.
REQ-025 EMIT: out_valid=1; out_data/out_row/out_col/out_ch SHALL stay stable until out_valid&&out_ready.
REQ-026 On handshake: k increments; k=CH-1 wraps to 0 and ox increments; ox=OUT_DIM-1 wraps to 0 and oy increments; next state READ.
REQ-027 Handshake on oy=ox=OUT_DIM-1, k=CH-1 SHALL go to FIN; FIN asserts done for one cycle, then IDLE.
REQ-028 Latency: first out_valid SHALL rise 11 cycles after the start-accepting edge; with out_ready held high, outputs every 11 cycles; pass = 69984 results.
REQ-029 mem_rd_en SHALL be 1 only in READ; mem_addr SHALL hold its last value otherwise.
REQ-030 busy SHALL be 1 in READ, DRAIN, EMIT, FIN; 0 in IDLE.
REQ-031 Max row/col address SHALL be 54; no read SHALL exceed address IN_DIM*IN_DIM*CH-1 = 290399.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE, clear all counters and accumulator, and drive busy, done, mem_rd_en, out_valid, mem_addr, out_data, out_row, out_col, out_ch to 0.
REQ-033 Reset mid-pass SHALL abort without done; a pending out_valid SHALL drop the cycle after reset is sampled.
REQ-034 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-035 Map value = (row*55+col)%1000, start with out_ready=1 -> first out_data=112 (row2,col2), out_valid at cycle 11, first addr sequence 0,96,192,5280,....
REQ-036 Window with taps -5,-32768,-1,...(all negative) -> out_data=-1 (no zero floor).
REQ-037 out_ready=0 for 20 cycles during EMIT -> out_valid held, outputs stable, no reads issued.
REQ-038 Full pass, out_ready=1 -> 69984 handshakes, order k fastest then ox then oy, last tuple (26,26,95), done one cycle after, busy low next.
REQ-039 rst_n=0 during READ of pixel (3,4,10) -> all outputs 0 next cycle; new start restarts at (0,0,0).
REQ-040 start pulsed while busy -> ignored; counters unaffected.

Source files
------------

// File: rtl/pool1_reader.sv
// 3x3 stride-2 signed max-pool reader: walks every (oy, ox, k) output, fetches the
// nine window taps one per cycle, and hands the window max downstream with valid/ready.
module pool1_reader #(
  parameter int IN_DIM  = 55,
  parameter int OUT_DIM = 27,
  parameter int CH      = 96,
  parameter int DW      = 16,
  parameter int AW      = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [4:0]    out_row,
  output logic [4:0]    out_col,
  output logic [6:0]    out_ch
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_EMIT, S_FIN} state_t;

  localparam logic [4:0] O_LAST = 5'(OUT_DIM - 1);
  localparam logic [6:0] K_LAST = 7'(CH - 1);

  state_t        r_state, w_nxt;
  logic [4:0]    r_oy, r_ox;
  logic [6:0]    r_k;
  logic [3:0]    r_tap;
  logic [DW-1:0] r_acc;
  logic [AW-1:0] r_addr_hold;
  logic          r_rd_vld, r_rd_first;

  logic          w_rd, w_hs, w_last;
  logic [1:0]    w_dy, w_dx;
  logic [5:0]    w_row, w_col;
  logic [AW-1:0] w_addr;

  assign w_rd   = (r_state == S_READ);
  assign w_hs   = (r_state == S_EMIT) && out_ready;
  assign w_last = (r_oy == O_LAST) && (r_ox == O_LAST) && (r_k == K_LAST);

  // Tap index -> window offset, row-major over the 3x3 window.
  always_comb begin
    w_dy = 2'd0;
    w_dx = 2'd0;
    case (r_tap)
      4'd1: w_dx = 2'd1;
      4'd2: w_dx = 2'd2;
      4'd3: w_dy = 2'd1;
      4'd4: begin w_dy = 2'd1; w_dx = 2'd1; end
      4'd5: begin w_dy = 2'd1; w_dx = 2'd2; end
      4'd6: w_dy = 2'd2;
      4'd7: begin w_dy = 2'd2; w_dx = 2'd1; end
      4'd8: begin w_dy = 2'd2; w_dx = 2'd2; end
      default: ;
    endcase
  end

  assign w_row  = {r_oy, 1'b0} + {4'd0, w_dy};
  assign w_col  = {r_ox, 1'b0} + {4'd0, w_dx};
  assign w_addr = (AW'(w_row) * AW'(IN_DIM) + AW'(w_col)) * AW'(CH) + AW'(r_k);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_READ;
      S_READ:  if (r_tap == 4'd8) w_nxt = S_DRAIN;
      S_DRAIN: w_nxt = S_EMIT;
      S_EMIT:  if (out_ready) w_nxt = w_last ? S_FIN : S_READ;
      S_FIN:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_FIN);
    mem_rd_en = w_rd;
    out_valid = (r_state == S_EMIT);
    mem_addr  = w_rd ? w_addr : r_addr_hold;
    out_data  = r_acc;
    out_row   = r_oy;
    out_col   = r_ox;
    out_ch    = r_k;
  end

  // Position counters: k fastest, then ox, then oy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_oy  <= '0;
      r_ox  <= '0;
      r_k   <= '0;
      r_tap <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_oy  <= '0;
          r_ox  <= '0;
          r_k   <= '0;
          r_tap <= '0;
        end
        S_READ: r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
        S_EMIT: if (w_hs && !w_last) begin
          if (r_k == K_LAST) begin
            r_k <= '0;
            if (r_ox == O_LAST) begin
              r_ox <= '0;
              r_oy <= r_oy + 5'd1;
            end else begin
              r_ox <= r_ox + 5'd1;
            end
          end else begin
            r_k <= r_k + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lands one cycle after the request; tap 0 seeds the max so
  // all-negative windows are not floored at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_vld    <= 1'b0;
      r_rd_first  <= 1'b0;
      r_acc       <= '0;
      r_addr_hold <= '0;
    end else begin
      r_rd_vld   <= w_rd;
      r_rd_first <= w_rd && (r_tap == 4'd0);
      if (w_rd) r_addr_hold <= w_addr;
      if (r_rd_vld && (r_rd_first || ($signed(mem_rd_data) > $signed(r_acc))))
        r_acc <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_pool1_reader.sv
// Directed bench for pool1_reader: a full-size instance for latency, addressing,
// stall, reset and signed-max cases, plus a shrunken instance for a full pass.
module tb_pool1_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mode  = 0;

  // Full-size instance
  logic        a_start, a_busy, a_done, a_rd, a_ov, a_rdy;
  logic [18:0] a_addr;
  logic [15:0] a_rdata, a_dout;
  logic [4:0]  a_row, a_col;
  logic [6:0]  a_ch;
  int          a_done_cnt = 0;

  pool1_reader u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rd_data(a_rdata),
    .out_valid(a_ov), .out_ready(a_rdy), .out_data(a_dout),
    .out_row(a_row), .out_col(a_col), .out_ch(a_ch)
  );

  // Shrunken instance: 7x7x3 in, 3x3x3 out
  logic        b_start, b_busy, b_done, b_rd, b_ov, b_rdy;
  logic [18:0] b_addr;
  logic [15:0] b_rdata, b_dout;
  logic [4:0]  b_row, b_col;
  logic [6:0]  b_ch;
  int          b_done_cnt = 0;

  pool1_reader #(.IN_DIM(7), .OUT_DIM(3), .CH(3), .DW(16), .AW(19)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rd_data(b_rdata),
    .out_valid(b_ov), .out_ready(b_rdy), .out_data(b_dout),
    .out_row(b_row), .out_col(b_col), .out_ch(b_ch)
  );

  // Feature-map model. mode 0: (row*dim+col)%1000; modes 1/2: fixed 3x3 corner.
  function automatic logic [15:0] fmval(int addr, int dim, int ch, int md);
    int pix, r, c;
    pix = addr / ch;
    r   = pix / dim;
    c   = pix % dim;
    if (md == 0) return 16'((r * dim + c) % 1000);
    if (r >= 3 || c >= 3) return 16'hFFF9;
    case (r * 3 + c)
      0: return 16'hFFFB;                          // -5
      1: return 16'h8000;                          // -32768
      2: return 16'hFFFF;                          // -1
      3: return 16'hFFFE;                          // -2
      4: return (md == 2) ? 16'h0003 : 16'hFED4;   // +3 / -300
      5: return 16'hFFF7;                          // -9
      6: return 16'h8001;                          // -32767
      7: return 16'hFFFC;                          // -4
      default: return 16'hFFFA;                    // -6
    endcase
  endfunction

  always @(posedge clk) begin
    a_rdata <= a_rd ? fmval(int'(a_addr), 55, 96, mode) : 16'h0;
    b_rdata <= b_rd ? fmval(int'(b_addr), 7, 3, 0) : 16'h0;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (b_done) b_done_cnt <= b_done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_a_valid(input int lim);
    int i;
    i = 0;
    while (!a_ov && i < lim) begin
      tick();
      i++;
    end
    chk("a_vld_wait", {31'd0, a_ov}, 32'd1);
  endtask

  task automatic a_go();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    cyc = 1;
  endtask

  logic [18:0] exp_addr [9];
  int prev;

  initial begin
    exp_addr = '{19'd0, 19'd96, 19'd192, 19'd5280, 19'd5376, 19'd5472,
                 19'd10560, 19'd10656, 19'd10752};
    rst_n = 1'b0; a_start = 1'b1; b_start = 1'b1; a_rdy = 1'b1; b_rdy = 1'b1;
    repeat (3) tick();

    // Reset with start held: everything zero
    chk("rst_ctl",   {28'd0, a_busy, a_done, a_rd, a_ov}, 32'd0);
    chk("rst_addr",  {13'd0, a_addr}, 32'd0);
    chk("rst_data",  {16'd0, a_dout}, 32'd0);
    chk("rst_coord", {15'd0, a_row, a_col, a_ch}, 32'd0);
    rst_n = 1'b1; a_start = 1'b0; b_start = 1'b0;
    tick();
    chk("start_in_rst_ignored", {31'd0, a_busy}, 32'd0);

    // First pixel: address sequence, drain hold, latency, value
    a_go();
    chk("busy_on", {31'd0, a_busy}, 32'd1);
    for (int t = 0; t < 9; t++) begin
      chk($sformatf("rd_en_t%0d", t), {31'd0, a_rd}, 32'd1);
      chk($sformatf("addr_t%0d", t), {13'd0, a_addr}, {13'd0, exp_addr[t]});
      tick();
    end
    chk("drain_no_rd", {30'd0, a_rd, a_ov}, 32'd0);
    chk("drain_addr_hold", {13'd0, a_addr}, 32'd10752);
    wait_a_valid(20);
    chk("first_vld_cyc", cyc, 11);
    chk("px000_data", {16'd0, a_dout}, 32'd112);
    chk("px000_coord", {15'd0, a_row, a_col, a_ch}, 32'd0);
    prev = cyc;
    tick();
    chk("hs_drop_vld", {31'd0, a_ov}, 32'd0);
    chk("k1_addr", {13'd0, a_addr}, 32'd1);
    chk("k1_ch", {25'd0, a_ch}, 32'd1);
    wait_a_valid(20);
    chk("period", cyc - prev, 11);
    chk("px001_data", {16'd0, a_dout}, 32'd112);

    // Back-pressure: 20 stalled cycles, outputs frozen, no reads
    a_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_vld", {31'd0, a_ov}, 32'd1);
      chk("stall_rd", {31'd0, a_rd}, 32'd0);
      chk("stall_data", {16'd0, a_dout}, 32'd112);
      chk("stall_coord", {15'd0, a_row, a_col, a_ch}, {15'd0, 5'd0, 5'd0, 7'd1});
    end
    a_rdy = 1'b1;
    tick();
    chk("stall_release_ch", {25'd0, a_ch}, 32'd2);

    // start while busy is ignored
    prev = cyc - 1;
    repeat (3) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_a_valid(20);
    chk("busy_start_period", cyc - prev, 11);
    chk("busy_start_ch", {25'd0, a_ch}, 32'd2);
    tick();
    chk("k3_addr", {13'd0, a_addr}, 32'd3);
    chk("k3_ch", {25'd0, a_ch}, 32'd3);

    // Abort mid-READ
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_ctl", {28'd0, a_busy, a_done, a_rd, a_ov}, 32'd0);
    chk("abort_addr", {13'd0, a_addr}, 32'd0);
    chk("abort_data", {16'd0, a_dout}, 32'd0);
    chk("abort_coord", {15'd0, a_row, a_col, a_ch}, 32'd0);
    chk("abort_no_done", a_done_cnt, 0);
    a_go();
    chk("restart_addr", {13'd0, a_addr}, 32'd0);
    wait_a_valid(20);
    chk("restart_data", {16'd0, a_dout}, 32'd112);
    chk("restart_coord", {15'd0, a_row, a_col, a_ch}, 32'd0);

    // Reset while a result is pending
    a_rdy = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_in_emit_vld", {31'd0, a_ov}, 32'd0);
    a_rdy = 1'b1;

    // All-negative window: max -1, no zero floor
    mode = 1;
    a_go();
    wait_a_valid(20);
    chk("neg_window", {16'd0, a_dout}, 32'h0000FFFF);
    // Mixed signs: signed compare picks +3
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mode = 2;
    a_go();
    wait_a_valid(20);
    chk("mixed_window", {16'd0, a_dout}, 32'h00000003);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("a_no_done", a_done_cnt, 0);

    // Full pass on the shrunken instance
    begin
      int n, eoy, eox, ek, bmax, ed;
      n = 0; eoy = 0; eox = 0; ek = 0; bmax = 0;
      b_start = 1'b1; tick(); b_start = 1'b0;
      for (int c = 0; c < 2000 && n < 27; c++) begin
        tick();
        if (b_rd && int'(b_addr) > bmax) bmax = int'(b_addr);
        if (b_ov) begin
          ed = (2 * eoy + 2) * 7 + 2 * eox + 2;
          chk($sformatf("pass_tuple%0d", n), {15'd0, b_row, b_col, b_ch},
              {15'd0, 5'(eoy), 5'(eox), 7'(ek)});
          chk($sformatf("pass_data%0d", n), {16'd0, b_dout}, 32'(ed));
          n++;
          if (ek == 2) begin
            ek = 0;
            if (eox == 2) begin eox = 0; eoy++; end else eox++;
          end else ek++;
        end
      end
      chk("pass_count", n, 27);
      chk("pass_max_addr", bmax, 146);
      chk("pass_no_early_done", b_done_cnt, 0);
      tick();
      chk("pass_done", {30'd0, b_done, b_busy}, 32'd3);
      tick();
      chk("pass_idle", {30'd0, b_done, b_busy}, 32'd0);
      chk("pass_done_once", b_done_cnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
